// File: rtl/nrzi_link_pkg.sv
// Shared definitions for the NRZI transition link: serializer FSM encoding and link defaults.
// Also intended for use by a stuff-aware receiver.
package nrzi_link_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StStuff
    } nrzi_state_e;

    localparam int unsigned StuffLenDefault  = 6;
    localparam logic        InitLevelDefault = 1'b1;

endpackage

// File: rtl/nrzi_line_reg.sv
// NRZI line output register: toggles the line on an emitted 1 and flags valid/stuff bits.
module nrzi_line_reg
    import nrzi_link_pkg::*;
#(
    parameter logic INIT_LEVEL = InitLevelDefault
) (
    input  logic clk,
    input  logic rst,
    input  logic emit_i,
    input  logic toggle_i,
    input  logic stuff_i,
    output logic ser_o,
    output logic valid_o,
    output logic stuff_o
);

    logic ser_q, valid_q, stuff_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ser_q   <= INIT_LEVEL;
            valid_q <= 1'b0;
            stuff_q <= 1'b0;
        end else begin
            valid_q <= emit_i;
            stuff_q <= emit_i & stuff_i;
            // Line keeps its last level when idle; it never returns to INIT_LEVEL.
            if (emit_i && toggle_i) begin
                ser_q <= ~ser_q;
            end
        end
    end

    assign ser_o   = ser_q;
    assign valid_o = valid_q;
    assign stuff_o = stuff_q;

endmodule

// File: rtl/nrzi_stuff_serializer.sv
// Parallel-to-serial NRZI transmitter with zero-run bit stuffing and valid/ready word intake.
module nrzi_stuff_serializer
    import nrzi_link_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STUFF_LEN  = StuffLenDefault,
    parameter logic        INIT_LEVEL = InitLevelDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              stuff_flag
);

    localparam int unsigned CntW  = $clog2(DATA_W + 1);
    localparam int unsigned ZrunW = $clog2(STUFF_LEN + 1);

    nrzi_state_e       state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ZrunW-1:0]  zrun_q, zrun_d;
    logic [ZrunW-1:0]  zrun_next;
    logic              bit_b, word_last;
    logic              emit, toggle, stuff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            zrun_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            zrun_q  <= zrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        zrun_d    = zrun_q;
        emit      = 1'b0;
        toggle    = 1'b0;
        stuff     = 1'b0;
        din_ready = 1'b0;
        bit_b     = shift_q[0];
        zrun_next = bit_b ? '0 : zrun_q + 1'b1;
        word_last = (cnt_q == CntW'(DATA_W - 1));

        unique case (state_q)
            StIdle: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    shift_d = din;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                emit    = 1'b1;
                toggle  = bit_b;
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                zrun_d  = zrun_next;
                // Stuff takes priority; a word ending on the stuff point completes from StStuff.
                if (zrun_next == ZrunW'(STUFF_LEN)) begin
                    state_d = StStuff;
                end else if (word_last) begin
                    din_ready = 1'b1;
                    if (din_valid) begin
                        shift_d = din;
                        cnt_d   = '0;
                    end else begin
                        state_d = StIdle;
                        zrun_d  = '0;
                    end
                end
            end
            StStuff: begin
                emit   = 1'b1;
                toggle = 1'b1;
                stuff  = 1'b1;
                zrun_d = '0;
                if (cnt_q == CntW'(DATA_W)) begin
                    din_ready = 1'b1;
                    if (din_valid) begin
                        shift_d = din;
                        cnt_d   = '0;
                        state_d = StShift;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    state_d = StShift;
                end
            end
            default: state_d = StIdle;
        endcase

        if (rst) begin
            din_ready = 1'b0;
        end
    end

    nrzi_line_reg #(
        .INIT_LEVEL(INIT_LEVEL)
    ) u_line_reg (
        .clk     (clk),
        .rst     (rst),
        .emit_i  (emit),
        .toggle_i(toggle),
        .stuff_i (stuff),
        .ser_o   (ser_out),
        .valid_o (ser_valid),
        .stuff_o (stuff_flag)
    );

endmodule

// File: tb/tb_nrzi_stuff_serializer.sv
// Directed bench for nrzi_stuff_serializer: per-cycle traces compared against hand-derived patterns.
module tb_nrzi_stuff_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       ser_out;
    logic       ser_valid;
    logic       stuff_flag;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [7:0]  word_q [4];
    int unsigned word_n;
    // Trace vectors: cycle 0 ends up as the most significant of the ncyc captured bits.
    logic [31:0] cap_valid, cap_out, cap_stuff, cap_ready;

    nrzi_stuff_serializer #(
        .DATA_W    (8),
        .STUFF_LEN (6),
        .INIT_LEVEL(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .stuff_flag(stuff_flag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic run(input int unsigned ncyc);
        int unsigned idx;
        logic        acc;
        idx       = 0;
        cap_valid = '0;
        cap_out   = '0;
        cap_stuff = '0;
        cap_ready = '0;
        for (int c = 0; c < int'(ncyc); c++) begin
            @(negedge clk);
            if (idx < word_n) begin
                din       = word_q[idx];
                din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            #1;
            acc       = din_valid & din_ready;
            cap_ready = {cap_ready[30:0], din_ready};
            @(posedge clk);
            if (acc) idx++;
            #1;
            cap_valid = {cap_valid[30:0], ser_valid};
            cap_out   = {cap_out[30:0], ser_out};
            cap_stuff = {cap_stuff[30:0], stuff_flag};
        end
        din_valid = 1'b0;
    endtask

    task automatic mid_reset(input string tag);
        @(negedge clk);
        rst       = 1'b1;
        din_valid = 1'b0;
        #1;
        check_eq({tag, "_ready"}, 32'(din_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_out"}, 32'(ser_out), 32'd1);
        check_eq({tag, "_valid"}, 32'(ser_valid), 32'd0);
        check_eq({tag, "_stuff"}, 32'(stuff_flag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_zero_word(input string tag);
        // 8'h00 from idle at line level 1: six holds, stuff toggle, two holds.
        word_q[0] = 8'h00;
        word_n    = 1;
        run(12);
        check_eq({tag, "_valid"}, cap_valid, 32'(12'b0_111111_1_11_00));
        check_eq({tag, "_out"},   cap_out,   32'(12'b1_111111_0_00_00));
        check_eq({tag, "_stuff"}, cap_stuff, 32'(12'b0_000000_1_00_00));
        check_eq({tag, "_ready"}, cap_ready, 32'(12'b1_000000_0_01_11));
    endtask

    initial begin
        // Reset held for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_eq("rst_ready", 32'(din_ready), 32'd0);
            @(posedge clk);
            #1;
            check_eq("rst_out", 32'(ser_out), 32'd1);
            check_eq("rst_valid", 32'(ser_valid), 32'd0);
            check_eq("rst_stuff", 32'(stuff_flag), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(din_ready), 32'd1);

        // 8'hA5 from idle, line starts at 1.
        word_q[0] = 8'hA5;
        word_n    = 1;
        run(11);
        check_eq("a5_valid", cap_valid, 32'(11'b0_11111111_00));
        check_eq("a5_out",   cap_out,   32'(11'b1_00111001_11));
        check_eq("a5_stuff", cap_stuff, 32'(11'b0_00000000_00));
        check_eq("a5_ready", cap_ready, 32'(11'b1_00000001_11));

        check_zero_word("w00");

        // 8'hFF then 8'h0F back-to-back, line starts at 0.
        word_q[0] = 8'hFF;
        word_q[1] = 8'h0F;
        word_n    = 2;
        run(19);
        check_eq("ff0f_valid", cap_valid, 32'(19'b0_11111111_11111111_00));
        check_eq("ff0f_out",   cap_out,   32'(19'b0_10101010_10100000_00));
        check_eq("ff0f_stuff", cap_stuff, 32'(19'b0_00000000_00000000_00));
        check_eq("ff0f_ready", cap_ready, 32'(19'b1_00000001_00000001_11));

        // 8'h07 then 8'hFE: zero run spans the word boundary, stuff after word 2 bit 0.
        word_q[0] = 8'h07;
        word_q[1] = 8'hFE;
        word_n    = 2;
        run(20);
        check_eq("07fe_valid", cap_valid, 32'(20'b0_11111111_1_1_1111111_00));
        check_eq("07fe_out",   cap_out,   32'(20'b0_10111111_1_0_1010101_11));
        check_eq("07fe_stuff", cap_stuff, 32'(20'b0_00000000_0_1_0000000_00));
        check_eq("07fe_ready", cap_ready, 32'(20'b1_00000001_0_0_0000001_11));

        // Reset after three bits of 8'h3C (line starts at 1).
        word_q[0] = 8'h3C;
        word_n    = 1;
        run(4);
        check_eq("3c_valid", cap_valid, 32'(4'b0111));
        check_eq("3c_out",   cap_out,   32'(4'b1110));
        mid_reset("rst3c");
        check_zero_word("post3c_w00");

        // Reset partway through a zero run: the next word must count zeros from scratch.
        word_q[0] = 8'h00;
        word_n    = 1;
        run(5);
        check_eq("z4_valid", cap_valid, 32'(5'b01111));
        check_eq("z4_out",   cap_out,   32'(5'b00000));
        mid_reset("rstz4");
        check_zero_word("postz4_w00");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
